// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of signed products from an upstream multiplier stage
// into a saturating accumulator, then holds the result until the consumer takes it.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - begin a new run (honoured only in idle)
//   len        - number of products in the run, sampled at an accepted start
//   prod_valid - upstream product valid
//   prod       - signed product, PROD_W bits
//   prod_ready - block accepts a product this cycle
//   acc_out    - signed accumulator register, qualified by acc_valid
//   acc_valid  - result valid (hold state)
//   acc_ready  - downstream accepts the result
//   sat_flag   - a clamp occurred in the current or last run (sticky until next start)
//   busy       - run in progress or result pending
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              sat_flag,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam int unsigned ExtW = ACC_W + 1 - PROD_W;
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic             clamp;

  // One guard bit is enough: both operands fit in ACC_W signed bits, so the sum cannot
  // wrap at ACC_W+1. Overflow shows up as the guard bit disagreeing with the ACC_W sign.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{ExtW{prod[PROD_W-1]}}, prod};
    clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (!clamp) begin
      sum_sat = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      sum_sat = AccMin;
    end else begin
      sum_sat = AccMax;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = len;
          // A zero-length run goes straight to presenting a zero result.
          state_d = (len != '0) ? StAccum : StHold;
        end
      end
      StAccum: begin
        if (prod_valid) begin
          acc_d = sum_sat;
          sat_d = sat_q | clamp;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (acc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come only from registers and state decode.
  assign prod_ready = (state_q == StAccum);
  assign acc_valid  = (state_q == StHold);
  assign busy       = (state_q != StIdle);
  assign acc_out    = acc_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        len = '0;
  logic              prod_valid = 1'b0;
  logic signed [7:0] prod = '0;
  logic              acc_ready = 1'b0;

  logic               prod_ready, acc_valid, sat_flag, busy;
  logic signed [15:0] acc_out;

  // Narrow-accumulator instance sharing the same stimulus: at the default widths the most
  // a run can reach is 255*127 = 32385 or 255*-128 = -32640, so clamping is exercised here.
  logic               prod_ready_n, acc_valid_n, sat_flag_n, busy_n;
  logic signed [11:0] acc_out_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  product_accumulator #(
    .PROD_W (8),
    .ACC_W  (12),
    .CNT_W  (8)
  ) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready_n),
    .acc_out    (acc_out_n),
    .acc_valid  (acc_valid_n),
    .acc_ready  (acc_ready),
    .sat_flag   (sat_flag_n),
    .busy       (busy_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completes the result handshake from the hold state.
  task automatic release_result();
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_out, acc_valid, prod_ready, busy, sat_flag} !== 20'h0) begin
      errors++;
      $display("FAIL reset_async: acc_out=%0d valid=%b ready=%b busy=%b sat=%b required all 0",
               acc_out, acc_valid, prod_ready, busy, sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({acc_valid, prod_ready, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: valid=%b ready=%b busy=%b required 000",
               acc_valid, prod_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic signed [7:0] v [3] = '{8'sd7, -8'sd6, 8'sd12};
    start = 1'b1;
    len   = 8'd3;
    step();
    start = 1'b0;
    len   = 8'd99;
    checks++;
    if ({prod_ready, busy, acc_valid} !== 3'b110) begin
      errors++;
      $display("FAIL basic_enter_accum: ready/busy/valid=%b%b%b required 110",
               prod_ready, busy, acc_valid);
    end
    prod_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prod = v[i];
      step();
      if (i == 1) begin
        checks++;
        if (acc_valid !== 1'b0 || acc_out !== 16'sd1) begin
          errors++;
          $display("FAIL basic_mid: valid=%b acc=%0d required 0 and 1", acc_valid, acc_out);
        end
      end
    end
    prod_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 16'sd13 || sat_flag !== 1'b0 || prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: valid=%b acc=%0d sat=%b ready=%b required 1 13 0 0",
               acc_valid, acc_out, sat_flag, prod_ready);
    end
    release_result();
    checks++;
    if (busy !== 1'b0 || acc_valid !== 1'b0 || acc_out !== 16'sd13 || acc_out_n !== 12'sd13) begin
      errors++;
      $display("FAIL basic_idle: busy=%b valid=%b acc=%0d acc_n=%0d required 0 0 13 13",
               busy, acc_valid, acc_out, acc_out_n);
    end
  endtask

  task automatic test_gaps();
    logic signed [7:0]  v [4]  = '{8'sd10, -8'sd3, 8'sd0, -8'sd8};
    logic signed [15:0] ex [4] = '{16'sd10, 16'sd7, 16'sd7, -16'sd1};
    start = 1'b1;
    len   = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1;
      prod       = v[i];
      step();
      prod_valid = 1'b0;
      prod       = 8'sd55;  // ignored while prod_valid is low
      if (i < 3) begin
        step();
        step();
        checks++;
        if (acc_out !== ex[i] || acc_valid !== 1'b0 || prod_ready !== 1'b1) begin
          errors++;
          $display("FAIL gaps_hold_%0d: acc=%0d valid=%b ready=%b required %0d 0 1",
                   i, acc_out, acc_valid, prod_ready, ex[i]);
        end
      end
    end
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== -16'sd1 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: valid=%b acc=%0d sat=%b required 1 -1 0",
               acc_valid, acc_out, sat_flag);
    end
    release_result();
  endtask

  task automatic test_saturation();
    int not_ready = 0;
    start = 1'b1;
    len   = 8'd255;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 8'sd127;
    for (int i = 0; i < 255; i++) begin
      if (prod_ready !== 1'b1 || acc_valid !== 1'b0) not_ready++;
      step();
    end
    prod_valid = 1'b0;
    checks++;
    if (not_ready != 0) begin
      errors++;
      $display("FAIL sat_all_accepted: stalled cycles=%0d required 0", not_ready);
    end
    // 255 * 127 = 32385: in range for a 16-bit accumulator.
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 16'sd32385 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide_result: valid=%b acc=%0d sat=%b required 1 32385 0",
               acc_valid, acc_out, sat_flag);
    end
    checks++;
    if (acc_valid_n !== 1'b1 || acc_out_n !== 12'sd2047 || sat_flag_n !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos_clamp: valid=%b acc=%0d sat=%b required 1 2047 1",
               acc_valid_n, acc_out_n, sat_flag_n);
    end
    release_result();
    checks++;
    if (sat_flag_n !== 1'b1 || acc_out_n !== 12'sd2047 || busy_n !== 1'b0) begin
      errors++;
      $display("FAIL sat_sticky_idle: sat=%b acc=%0d busy=%b required 1 2047 0",
               sat_flag_n, acc_out_n, busy_n);
    end
    start = 1'b1;
    len   = 8'd20;
    step();
    start = 1'b0;
    checks++;
    if (sat_flag_n !== 1'b0 || acc_out_n !== 12'sd0) begin
      errors++;
      $display("FAIL sat_clear_on_start: sat=%b acc=%0d required 0 0", sat_flag_n, acc_out_n);
    end
    prod_valid = 1'b1;
    prod       = -8'sd128;
    for (int i = 0; i < 20; i++) step();
    prod_valid = 1'b0;
    checks++;
    if (acc_out_n !== -12'sd2048 || sat_flag_n !== 1'b1 || acc_out !== -16'sd2560 ||
        sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_neg_clamp: acc_n=%0d sat_n=%b acc=%0d sat=%b required -2048 1 -2560 0",
               acc_out_n, sat_flag_n, acc_out, sat_flag);
    end
    release_result();
  endtask

  task automatic test_len_zero();
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 16'sd0 || busy !== 1'b1 || prod_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: valid=%b acc=%0d busy=%b ready=%b required 1 0 1 0",
               acc_valid, acc_out, busy, prod_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (acc_valid !== 1'b1 || acc_out !== 16'sd0) begin
        errors++;
        $display("FAIL zero_stable_%0d: valid=%b acc=%0d required 1 0", i, acc_valid, acc_out);
      end
    end
    release_result();
    checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_to_idle: valid=%b busy=%b required 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int stray = 0;
    start = 1'b1;
    len   = 8'd5;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 8'sd3;
    step();
    prod = 8'sd4;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (acc_out !== 16'sd0 || {acc_valid, prod_ready, busy, sat_flag} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset: acc=%0d valid=%b ready=%b busy=%b sat=%b required all 0",
               acc_out, acc_valid, prod_ready, busy, sat_flag);
    end
    step();
    rst_n      = 1'b1;
    prod_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (acc_valid !== 1'b0 || busy !== 1'b0) stray++;
      step();
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midrun_no_valid: stray cycles=%0d required 0", stray);
    end
    start = 1'b1;
    len   = 8'd1;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = -8'sd128;
    step();
    prod_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== -16'sd128) begin
      errors++;
      $display("FAIL midrun_restart: valid=%b acc=%0d required 1 -128", acc_valid, acc_out);
    end
    release_result();
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    len   = 8'd2;
    step();
    len        = 8'd7;  // held start with a new len must be ignored while busy
    prod_valid = 1'b1;
    prod       = 8'sd5;
    step();
    checks++;
    if (acc_out !== 16'sd5 || prod_ready !== 1'b1) begin
      errors++;
      $display("FAIL ign_accum: acc=%0d ready=%b required 5 1", acc_out, prod_ready);
    end
    prod = 8'sd6;
    step();
    prod_valid = 1'b0;
    len        = 8'd0;
    step();
    step();
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 16'sd11) begin
      errors++;
      $display("FAIL ign_hold: valid=%b acc=%0d required 1 11", acc_valid, acc_out);
    end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc_valid !== 1'b0 || acc_out !== 16'sd11) begin
      errors++;
      $display("FAIL ign_handshake: busy=%b valid=%b acc=%0d required 0 0 11",
               busy, acc_valid, acc_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_len_zero();
    test_reset_midrun();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
